// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg7_pkg;

  localparam int DIGITS             = 4;
  localparam int NIBBLE_W           = 4;
  localparam int IDX_W              = 2;
  // 100 MHz / 50000 = 2 kHz digit rate, 500 Hz full-frame rate.
  localparam int REFRESH_DIV_100MHZ = 50000;

  typedef logic [IDX_W-1:0]    digit_idx_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/refresh_tick_gen.sv
// Modulo-DIV free-running counter emitting a one-cycle tick on its last count.
// Latency: tick is combinational from the count register (high when count == DIV-1).
// Backpressure: none; free-running.
//
// Ports:
//   i_clk   - clock, all state on rising edge
//   i_rst_n - asynchronous active-low reset, count returns to 0
//   o_tick  - high during the final cycle of each DIV-cycle period
module refresh_tick_gen #(
  parameter int DIV   = 50000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a 4-digit 7-segment display with a tear-free shadow/active value register.
// Latency: accepted value becomes visible in slot 0 of the first frame that starts after the accept edge.
// Backpressure: LOAD_READY_OUT low while a shadow value awaits its frame-boundary commit.
//
// Ports:
//   CLK, RESETN          - clock and asynchronous active-low reset
//   LOAD_VALID_IN/READY  - valid/ready load handshake for VALUE_IN (4 nibbles) and DOTS_IN
//   LZ_BLANK_IN          - level, enables leading-zero blanking
//   SEG_SELECT_OUT       - current digit index (0 = rightmost)
//   BIN_OUT, DOT_OUT     - raw nibble and dot of the current digit
//   BLANK_OUT            - current digit must be dark
//   FRAME_DONE_OUT       - one-cycle pulse after digit 3 wraps to digit 0
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_100MHZ,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         LOAD_VALID_IN,
  output logic                         LOAD_READY_OUT,
  input  logic [DIGITS*NIBBLE_W-1:0]   VALUE_IN,
  input  logic [DIGITS-1:0]            DOTS_IN,
  input  logic                         LZ_BLANK_IN,
  output logic [IDX_W-1:0]             SEG_SELECT_OUT,
  output logic [NIBBLE_W-1:0]          BIN_OUT,
  output logic                         DOT_OUT,
  output logic                         BLANK_OUT,
  output logic                         FRAME_DONE_OUT
);

  localparam digit_idx_t LAST_IDX = IDX_W'(DIGITS - 1);

  digit_idx_t                     r_idx;
  logic [DIGITS*NIBBLE_W-1:0]     r_active;
  logic [DIGITS-1:0]              r_active_dots;
  logic [DIGITS*NIBBLE_W-1:0]     r_shadow;
  logic [DIGITS-1:0]              r_shadow_dots;
  logic                           r_pending;
  logic                           r_frame_done;

  logic                           w_tick;
  logic                           w_wrap;
  logic                           w_accept;
  logic [DIGITS-1:0]              w_nonempty;
  logic [DIGITS-1:0]              w_blank_mask;

  refresh_tick_gen #(
    .DIV   (REFRESH_DIV),
    .CNT_W (CNT_W)
  ) u_tick (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .o_tick  (w_tick)
  );

  assign w_wrap   = w_tick && (r_idx == LAST_IDX);
  // Ready depends only on the pending flag, so no combinational path from valid.
  assign w_accept = LOAD_VALID_IN && !r_pending;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_idx         <= '0;
      r_active      <= '0;
      r_active_dots <= '0;
      r_shadow      <= '0;
      r_shadow_dots <= '0;
      r_pending     <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (w_tick) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      // Commit needs pending=1 and accept needs pending=0, so the two never collide.
      // An accept landing on the wrap tick waits for the following frame boundary.
      if (w_wrap && r_pending) begin
        r_active      <= r_shadow;
        r_active_dots <= r_shadow_dots;
        r_pending     <= 1'b0;
      end else if (w_accept) begin
        r_shadow      <= VALUE_IN;
        r_shadow_dots <= DOTS_IN;
        r_pending     <= 1'b1;
      end
    end
  end

  // A digit is non-empty if its nibble or its dot is set; digit k is blanked
  // when no non-empty digit exists at position k or above. Digit 0 always shows.
  for (genvar k = 0; k < DIGITS; k++) begin : g_empty
    assign w_nonempty[k] = (r_active[k*NIBBLE_W +: NIBBLE_W] != '0) || r_active_dots[k];
  end

  always_comb begin
    w_blank_mask = '0;
    for (int k = 1; k < DIGITS; k++) begin
      w_blank_mask[k] = ~|(w_nonempty >> k);
    end
  end

  assign LOAD_READY_OUT = !r_pending;
  assign SEG_SELECT_OUT = r_idx;
  assign BIN_OUT        = r_active[r_idx*NIBBLE_W +: NIBBLE_W];
  assign DOT_OUT        = r_active_dots[r_idx];
  assign BLANK_OUT      = LZ_BLANK_IN && w_blank_mask[r_idx];
  assign FRAME_DONE_OUT = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with REFRESH_DIV=4 (16-cycle frames).
// Stimulus pushes the hand-derived expected outputs per cycle; a negedge monitor pops and compares.
// Frames are driven aligned to the slot-0 cycle that follows reset release.
module tb_seg7_scan_ctrl;

  logic        CLK;
  logic        RESETN;
  logic        LOAD_VALID_IN;
  logic        LOAD_READY_OUT;
  logic [15:0] VALUE_IN;
  logic [3:0]  DOTS_IN;
  logic        LZ_BLANK_IN;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;
  logic        BLANK_OUT;
  logic        FRAME_DONE_OUT;

  seg7_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .CLK            (CLK),
    .RESETN         (RESETN),
    .LOAD_VALID_IN  (LOAD_VALID_IN),
    .LOAD_READY_OUT (LOAD_READY_OUT),
    .VALUE_IN       (VALUE_IN),
    .DOTS_IN        (DOTS_IN),
    .LZ_BLANK_IN    (LZ_BLANK_IN),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .BIN_OUT        (BIN_OUT),
    .DOT_OUT        (DOT_OUT),
    .BLANK_OUT      (BLANK_OUT),
    .FRAME_DONE_OUT (FRAME_DONE_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         fid;
    int         cyc;
    logic [1:0] sel;
    logic [3:0] bin;
    logic       dot;
    logic       blank;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push_exp(input int fid, input int cyc, input logic [1:0] sel, input logic [3:0] bin,
                          input logic dot, input logic blank, input logic fd, input logic rdy);
    exp_t e;
    e.fid = fid; e.cyc = cyc; e.sel = sel; e.bin = bin;
    e.dot = dot; e.blank = blank; e.fd = fd; e.rdy = rdy;
    q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare away from the rising edge.
  initial begin
    exp_t e;
    logic [9:0] got;
    logic [9:0] want;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e    = q.pop_front();
        got  = {SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, FRAME_DONE_OUT, LOAD_READY_OUT};
        want = {e.sel, e.bin, e.dot, e.blank, e.fd, e.rdy};
        n_tests++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL out[f%0d c%0d] got sel=%0d bin=%h dot=%b blank=%b fd=%b rdy=%b required sel=%0d bin=%h dot=%b blank=%b fd=%b rdy=%b",
                   e.fid, e.cyc, SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, FRAME_DONE_OUT, LOAD_READY_OUT,
                   e.sel, e.bin, e.dot, e.blank, e.fd, e.rdy);
        end
      end
    end
  end

  // Called just after a rising edge. Drives ncyc cycles of one frame; ev/ed/eb are the
  // hand-computed displayed value, dots and per-slot blank for this frame.
  task automatic do_frame(input int fid, input logic [15:0] ev, input logic [3:0] ed, input logic [3:0] eb,
                          input logic fd0, input logic [15:0] rdy, input logic [15:0] vld,
                          input logic [15:0] din, input logic [3:0] dd, input logic chg,
                          input logic lz, input int ncyc);
    int s;
    for (int c = 0; c < ncyc; c++) begin
      s             = c / 4;
      LZ_BLANK_IN   = lz;
      LOAD_VALID_IN = vld[c];
      VALUE_IN      = chg ? (din + 16'(c)) : din;
      DOTS_IN       = dd;
      push_exp(fid, c, 2'(s), ev[4*s +: 4], ed[s], eb[s], (c == 0) && fd0, rdy[c]);
      @(posedge CLK);
      #1;
    end
  endtask

  // Called just after a rising edge: asserts reset mid-cycle, checks outputs before the
  // next edge (asynchronous effect), then releases so the next cycle is slot 0, count 0.
  task automatic do_reset(input int fid);
    LOAD_VALID_IN = 1'b0;
    RESETN        = 1'b0;
    #1;
    push_exp(fid, -1, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    RESETN        = 1'b0;
    LOAD_VALID_IN = 1'b0;
    VALUE_IN      = 16'h0000;
    DOTS_IN       = 4'h0;
    LZ_BLANK_IN   = 1'b0;
    @(posedge CLK);
    #1;
    do_reset(0);

    //        fid value    dots     blank    fd   rdy       vld       din      dd       chg   lz    n
    do_frame(1,  16'h0000, 4'b0000, 4'b0000, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0, 16);
    do_frame(2,  16'h0000, 4'b0000, 4'b0000, 1'b1, 16'h003F, 16'h0020, 16'hA3C7, 4'b0100, 1'b0, 1'b0, 16);
    do_frame(3,  16'hA3C7, 4'b0100, 4'b0000, 1'b1, 16'hFFFF, 16'h0000, 16'hA3C7, 4'b0100, 1'b0, 1'b0, 16);
    do_frame(4,  16'hA3C7, 4'b0100, 4'b0000, 1'b1, 16'h0001, 16'hFFFF, 16'h1000, 4'b0001, 1'b1, 1'b0, 16);
    do_frame(5,  16'h1000, 4'b0001, 4'b0000, 1'b1, 16'h0001, 16'hFFFF, 16'h2000, 4'b0010, 1'b1, 1'b0, 16);
    do_frame(6,  16'h2000, 4'b0010, 4'b0000, 1'b1, 16'hFFFF, 16'h8000, 16'h1234, 4'b0000, 1'b0, 1'b0, 16);
    do_frame(7,  16'h2000, 4'b0010, 4'b0000, 1'b1, 16'h0000, 16'h0000, 16'h1234, 4'b0000, 1'b0, 1'b0, 16);
    do_frame(8,  16'h1234, 4'b0000, 4'b0000, 1'b1, 16'h0001, 16'h0001, 16'h0050, 4'b0000, 1'b0, 1'b0, 16);
    do_frame(9,  16'h0050, 4'b0000, 4'b1100, 1'b1, 16'h0001, 16'h0001, 16'h0000, 4'b1000, 1'b0, 1'b1, 16);
    do_frame(10, 16'h0000, 4'b1000, 4'b0000, 1'b1, 16'h0001, 16'h0001, 16'h0000, 4'b0000, 1'b0, 1'b1, 16);
    do_frame(11, 16'h0000, 4'b0000, 4'b1110, 1'b1, 16'h0001, 16'h0001, 16'hBEEF, 4'b1111, 1'b0, 1'b1, 9);
    do_reset(12);
    do_frame(13, 16'h0000, 4'b0000, 4'b0000, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF, 4'b1111, 1'b0, 1'b0, 16);
    do_frame(14, 16'h0000, 4'b0000, 4'b0000, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 4'b1111, 1'b0, 1'b0, 16);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expectations required 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan scheduler for the Basys2 4-digit 7-segment display; drives the digit select, nibble and dot inputs of the existing combinational seg7 decoder.
- Holds a 16-bit display value and 4 dot bits in an active register, fed by a shadow buffer. New values are loaded via a valid/ready handshake and committed only at frame boundaries, so the display never tears.
- Sits between the PS/2 mouse status logic (producer) and the decoder (consumer).

Parameters:
REFRESH_DIV, 50000, CLK cycles per digit slot (100 MHz -> 2 kHz digit, 500 Hz frame); legal range >= 2
CNT_W, $clog2(REFRESH_DIV), width of the refresh counter

Ports:
CLK  in  1  system clock, all state on rising edge
RESETN  in  1  asynchronous active-low reset
LOAD_VALID_IN  in  1  producer offers VALUE_IN/DOTS_IN this cycle
LOAD_READY_OUT  out  1  shadow buffer free; transfer occurs when VALID and READY are both 1
VALUE_IN  in  16  four hex nibbles; [3:0] is the rightmost digit
DOTS_IN  in  4  decimal point per digit; bit k belongs to digit k
LZ_BLANK_IN  in  1  level; 1 enables leading-zero blanking
SEG_SELECT_OUT  out  2  current digit index, 0 = rightmost; to decoder select input
BIN_OUT  out  4  nibble of the current digit; to decoder data input
DOT_OUT  out  1  dot bit of the current digit, active-high
BLANK_OUT  out  1  1 = current digit must be dark (top level forces all anodes high)
FRAME_DONE_OUT  out  1  one-cycle pulse on the slot-3 -> slot-0 transition

Behaviour:
- Reset (async, RESETN=0) sets: refresh counter=0, digit index=0, active value=16'h0000, active dots=0, shadow pending=0.
- Output values during and after reset: SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, BLANK_OUT=0, FRAME_DONE_OUT=0, LOAD_READY_OUT=1.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. Tick = counter at REFRESH_DIV-1.
- On a tick, the digit index advances 0->1->2->3->0. Each digit is shown for exactly REFRESH_DIV cycles.
- FRAME_DONE_OUT is registered and is 1 for the single cycle after the tick at which index 3 wraps to 0.
- Handshake:
  - LOAD_READY_OUT = ~pending. This is combinational from the register only, with no path from LOAD_VALID_IN.
  - Accept (VALID & READY) latches VALUE_IN/DOTS_IN into the shadow and sets pending on the next edge.
  - While pending=1, VALID is ignored and the shadow holds.
- Commit:
  - On the wrap tick (index 3 -> 0), if pending=1, shadow is copied to active and pending is cleared in the same edge. The new value is first visible in slot 0 of the new frame.
  - Accept and wrap tick in the same cycle with pending=0: the accept sets pending and there is no commit that cycle. The value commits at the next frame boundary.
  - Commit and a new accept can never coincide, because READY=0 while pending=1. READY returns to 1 the cycle after commit.
- Outputs SEG_SELECT_OUT, BIN_OUT, DOT_OUT and BLANK_OUT are combinational functions of the index and active registers only. They change only on edges where the index or active register changes.
- BIN_OUT = active[4*idx+3 -: 4]; DOT_OUT = active_dots[idx].
- Leading-zero blanking, when LZ_BLANK_IN=1:
  - Digit k (k = 1..3) is blanked iff active nibbles k..3 are all 4'h0 and active dots k..3 are all 0.
  - Digit 0 is never blanked.
  - When LZ_BLANK_IN=0, BLANK_OUT=0.
  - BIN_OUT/DOT_OUT still carry the raw nibble while blanked.
- Reset mid-frame or mid-handshake: everything returns to the reset values immediately. The shadow content is discarded.

Decomposition:
- Shared package seg7_pkg: DIGITS=4, NIBBLE_W=4, localparam for digit index width (2), and the default REFRESH_DIV for a 100 MHz clock.
- One sub-module: refresh_tick_gen (parameterised modulo counter emitting a tick). The remaining logic (index, shadow/active, blanking) stays in seg7_scan_ctrl.

Test Plan (REFRESH_DIV=4):
- Reset then idle:
  - Expect SEG_SELECT_OUT = 0,0,0,0,1,1,1,1,2,...,3.
  - Expect FRAME_DONE_OUT high exactly once per 16 cycles, in the cycle after index 3 -> 0.
  - Expect BIN_OUT=0, LOAD_READY_OUT=1.
- Load 16'hA3C7, DOTS=4'b0100, mid-frame in slot 1:
  - READY drops the next cycle; active stays 0 until the wrap.
  - Next frame: BIN_OUT = 7, C, 3, A with DOT_OUT=1 only in slot 2; READY=1 one cycle after commit.
- VALID held high continuously with changing data:
  - Exactly one accept per frame.
  - The committed value equals the data present on the accept cycle; the shadow never changes while pending.
- Accept on the exact wrap-tick cycle with 16'h1234:
  - No commit in that frame.
  - 16'h1234 is visible from slot 0 of the following frame.
- LZ_BLANK_IN=1 with value 16'h0050:
  - BLANK_OUT = 0, 0, 1, 1 for slots 0..3.
- LZ_BLANK_IN=1 with value 16'h0000, dots 4'b1000:
  - BLANK_OUT = 0 in all slots (dot on digit 3 defeats blanking).
- Reset asserted mid-slot 2 with pending=1:
  - All outputs return to reset values asynchronously.
  - After release, the old shadow never appears and READY=1.
